// File: rtl/sprite_rom_pkg.sv
// Shared defaults and the pipeline tag type for the sprite ROM arbiter.
// Optional grant statistics are enabled with SPRITE_ROM_ARB_STATS_EN.
package sprite_rom_pkg;

    localparam int DEFAULT_NUM_REQ     = 4;
    localparam int DEFAULT_ADDR_W      = 17;
    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_ROM_LATENCY = 2;
    localparam int MAX_NUM_REQ         = 8;
    localparam int STAT_W              = 16;

    // Index field is wide enough for the largest legal requester count.
    localparam int TAG_IDX_W = $clog2(MAX_NUM_REQ);

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] index;
    } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: the search starts one past ptr_in and
// the lowest index after the pointer wins.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_in,
    input  logic [IDX_W-1:0] ptr_in,
    output logic [N-1:0]     grant_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             any_out
);

    int j;

    always_comb begin
        grant_out = '0;
        idx_out   = '0;
        any_out   = 1'b0;
        j         = 0;
        for (int off = 1; off <= N; off++) begin
            j = (int'(ptr_in) + off) % N;
            if (!any_out && req_in[j]) begin
                grant_out[j] = 1'b1;
                idx_out      = IDX_W'(j);
                any_out      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM port among NUM_REQ requesters.
// Define SPRITE_ROM_ARB_STATS_EN to add saturating per-requester grant counters.
module sprite_rom_arbiter
    import sprite_rom_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ROM_LATENCY = DEFAULT_ROM_LATENCY
) (
    input  logic                            pixel_clk_in,
    input  logic                            rst_in,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  addr_in,
    output logic [NUM_REQ-1:0]              grant_out,
    output logic [ADDR_W-1:0]               rom_addr_out,
    input  logic [DATA_W-1:0]               rom_data_in,
    output logic [DATA_W-1:0]               data_out,
    output logic [NUM_REQ-1:0]              data_valid_out
`ifdef SPRITE_ROM_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][STAT_W-1:0]  stat_grants_out
`else
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    tag_t [ROM_LATENCY:0] tag_q, tag_d;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_in    (req_in),
        .ptr_in    (last_grant_q),
        .grant_out (pick_grant),
        .idx_out   (pick_idx),
        .any_out   (pick_any)
    );

    // Stage 0 captures the grant; the last stage lines up with ROM data.
    always_comb begin
        last_grant_d = pick_any ? pick_idx : last_grant_q;
        rom_addr_d   = pick_any ? addr_in[pick_idx] : rom_addr_q;
        tag_d        = tag_q;
        tag_d[0].valid = pick_any;
        tag_d[0].index = TAG_IDX_W'(pick_idx);
        for (int s = 1; s <= ROM_LATENCY; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            rom_addr_q   <= '0;
            tag_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rom_addr_q   <= rom_addr_d;
            tag_q        <= tag_d;
        end
    end

    always_comb begin
        grant_out      = rst_in ? '0 : pick_grant;
        rom_addr_out   = rst_in ? '0 : rom_addr_q;
        data_out       = rom_data_in;
        data_valid_out = '0;
        if (!rst_in && tag_q[ROM_LATENCY].valid) begin
            data_valid_out = NUM_REQ'(1) << tag_q[ROM_LATENCY].index;
        end
    end

`ifdef SPRITE_ROM_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_W-1:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i] && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_grants_out = stat_q;
`else
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed table-driven bench for sprite_rom_arbiter at default parameters.
// With SPRITE_ROM_ARB_STATS_EN defined it also checks counter saturation.
module tb_sprite_rom_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 8;

    logic                           clk;
    logic                           rst_in;
    logic [NUM_REQ-1:0]             req_in;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_in;
    logic [NUM_REQ-1:0]             grant_out;
    logic [ADDR_W-1:0]              rom_addr_out;
    logic [DATA_W-1:0]              rom_data_in;
    logic [DATA_W-1:0]              data_out;
    logic [NUM_REQ-1:0]             data_valid_out;
`ifdef SPRITE_ROM_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0]       stat_grants_out;
`endif

    int checks;
    int errors;

    sprite_rom_arbiter dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .req_in         (req_in),
        .addr_in        (addr_in),
        .grant_out      (grant_out),
        .rom_addr_out   (rom_addr_out),
        .rom_data_in    (rom_data_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out)
`ifdef SPRITE_ROM_ARB_STATS_EN
        ,
        .stat_grants_out(stat_grants_out)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: two-cycle latency, content = low address byte xor 8'h5A
    logic [DATA_W-1:0] rom_pipe0, rom_pipe1;
    always @(posedge clk) begin
        rom_pipe0 <= rom_addr_out[7:0] ^ 8'h5A;
        rom_pipe1 <= rom_pipe0;
    end
    assign rom_data_in = rom_pipe1;

    typedef struct {
        logic               rst;
        logic [NUM_REQ-1:0] req;
        logic [NUM_REQ-1:0] g;
        logic [ADDR_W-1:0]  a;
        logic [NUM_REQ-1:0] dv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] g,
                       input logic [16:0] a, input logic [3:0] dv);
        vec_t v;
        v.rst = rst; v.req = req; v.g = g; v.a = a; v.dv = dv;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_data(input logic [NUM_REQ-1:0] dv);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (dv[i]) d = addr_in[i][7:0] ^ 8'h5A;
        end
        return d;
    endfunction

    localparam logic [16:0] A0 = 17'h00123;
    localparam logic [16:0] A1 = 17'h0A001;
    localparam logic [16:0] A2 = 17'h1B002;
    localparam logic [16:0] A3 = 17'h0C003;

    initial begin
        checks  = 0;
        errors  = 0;
        rst_in  = 1'b1;
        req_in  = '0;
        addr_in[0] = A0; addr_in[1] = A1; addr_in[2] = A2; addr_in[3] = A3;
        repeat (3) @(posedge clk);

        //   rst   req      grant    rom_addr  data_valid
        add(1'b1, 4'b1111, 4'b0000, 17'h0, 4'b0000); // reset state
        add(1'b0, 4'b0001, 4'b0001, 17'h0, 4'b0000); // first cycle after reset
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0000);
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0000);
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0001); // 3 cycles after grant
        add(1'b1, 4'b0000, 4'b0000, 17'h0, 4'b0000); // reset, then all request
        add(1'b0, 4'b1111, 4'b0001, 17'h0, 4'b0000);
        add(1'b0, 4'b1111, 4'b0010, A0,    4'b0000);
        add(1'b0, 4'b1111, 4'b0100, A1,    4'b0000);
        add(1'b0, 4'b1111, 4'b1000, A2,    4'b0001);
        add(1'b0, 4'b1111, 4'b0001, A3,    4'b0010);
        add(1'b0, 4'b1111, 4'b0010, A0,    4'b0100);
        add(1'b0, 4'b1111, 4'b0100, A1,    4'b1000);
        add(1'b0, 4'b1111, 4'b1000, A2,    4'b0001);
        add(1'b0, 4'b0000, 4'b0000, A3,    4'b0010);
        add(1'b0, 4'b0000, 4'b0000, A3,    4'b0100);
        add(1'b0, 4'b0000, 4'b0000, A3,    4'b1000);
        add(1'b0, 4'b0000, 4'b0000, A3,    4'b0000);
        add(1'b0, 4'b0010, 4'b0010, A3,    4'b0000); // last grant -> 1
        add(1'b0, 4'b1010, 4'b1000, A1,    4'b0000); // 3 wins
        add(1'b0, 4'b1010, 4'b0010, A3,    4'b0000); // then 1
        add(1'b0, 4'b0000, 4'b0000, A1,    4'b0010);
        add(1'b0, 4'b0000, 4'b0000, A1,    4'b1000);
        add(1'b0, 4'b0000, 4'b0000, A1,    4'b0010);
        add(1'b0, 4'b0000, 4'b0000, A1,    4'b0000);
        add(1'b0, 4'b0100, 4'b0100, A1,    4'b0000); // req 2, idle, req 2
        add(1'b0, 4'b0000, 4'b0000, A2,    4'b0000);
        add(1'b0, 4'b0100, 4'b0100, A2,    4'b0000);
        add(1'b0, 4'b0000, 4'b0000, A2,    4'b0100);
        add(1'b0, 4'b0000, 4'b0000, A2,    4'b0000); // bubble
        add(1'b0, 4'b0000, 4'b0000, A2,    4'b0100);
        add(1'b0, 4'b0000, 4'b0000, A2,    4'b0000);
        add(1'b0, 4'b0011, 4'b0001, A2,    4'b0000); // two reads in flight
        add(1'b0, 4'b0011, 4'b0010, A0,    4'b0000);
        add(1'b1, 4'b0011, 4'b0000, 17'h0, 4'b0000); // reset pulse
        add(1'b0, 4'b0011, 4'b0001, 17'h0, 4'b0000); // requester 0 first
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0000);
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0000);
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0001);
        add(1'b0, 4'b0000, 4'b0000, A0,    4'b0000);

        // driver: inputs change at negedge, outputs sampled 1 ns later
        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rst_in = vecs[r].rst;
            req_in = vecs[r].req;
            #1;
            check("grant", r, 32'(grant_out), 32'(vecs[r].g));
            check("rom_addr", r, 32'(rom_addr_out), 32'(vecs[r].a));
            check("data_valid", r, 32'(data_valid_out), 32'(vecs[r].dv));
            if (vecs[r].dv != '0) begin
                check("data", r, 32'(data_out), 32'(exp_data(vecs[r].dv)));
            end
        end

`ifdef SPRITE_ROM_ARB_STATS_EN
        @(negedge clk);
        rst_in = 1'b1;
        req_in = '0;
        @(negedge clk);
        rst_in = 1'b0;
        req_in = 4'b0010;
        repeat (70000) @(negedge clk);
        req_in = '0;
        @(negedge clk);
        check("stat1", 1, 32'(stat_grants_out[1]), 32'h0000FFFF);
        check("stat0", 0, 32'(stat_grants_out[0]), 32'h0);
        check("stat2", 2, 32'(stat_grants_out[2]), 32'h0);
        check("stat3", 3, 32'(stat_grants_out[3]), 32'h0);
`endif

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
